// File: rtl/xb_cascade_fir.sv
// Cascade of STAGES serial-MAC FIR stages, each selecting a shared low or high coefficient bank.
// Define XB_DECIM2_EN to make every stage forward only every other result (decimate by 2).
module xb_cascade_fir #(
    parameter int DW     = 16,
    parameter int CW     = 16,
    parameter int TAPS   = 8,
    parameter int STAGES = 3,
    parameter int FRAC   = 15
) (
    input  logic                      phy_clk_0,
    input  logic                      reset,
    input  logic signed [DW-1:0]      data_in,
    input  logic                      data_in_read,
    output logic                      in_ready,
    input  logic [STAGES-1:0]         stage_mode,
    input  logic                      coef_we,
    input  logic                      coef_bank,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [CW-1:0]      coef_data,
    output logic                      busy,
    output logic signed [DW-1:0]      data_out,
    output logic                      data_out_valid,
    output logic [STAGES-1:0]         finish_stage,
    output logic                      finish,
    output logic                      overrun,
    input  logic                      ovr_clr
);
    localparam int AW   = $clog2(TAPS);
    localparam int KW   = AW + 1;
    localparam int ACCW = DW + CW + AW;
    localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic {S_IDLE = 1'b0, S_MAC = 1'b1} state_t;

    function automatic logic signed [DW-1:0] shift_sat(input logic signed [ACCW-1:0] a);
        logic signed [ACCW-1:0] s;
        s = a >>> FRAC;
        if (s > SAT_MAX) return SAT_MAX[DW-1:0];
        if (s < SAT_MIN) return SAT_MIN[DW-1:0];
        return s[DW-1:0];
    endfunction

    logic signed [CW-1:0] clo_q [TAPS];
    logic signed [CW-1:0] chi_q [TAPS];
    logic                 addr_ok;

    assign addr_ok = int'(coef_addr) < TAPS;

    always_ff @(posedge phy_clk_0 or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < TAPS; j++) begin
                clo_q[j] <= '0;
                chi_q[j] <= '0;
            end
        end else if (coef_we && !busy && addr_ok) begin
            if (coef_bank) chi_q[coef_addr] <= coef_data;
            else           clo_q[coef_addr] <= coef_data;
        end
    end

    logic [STAGES-1:0]    accept_w;
    logic [STAGES-1:0]    emit_w;
    logic [STAGES-1:0]    busy_w;
    logic signed [DW-1:0] din_w [STAGES];
    logic signed [DW-1:0] res_w [STAGES];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        state_t                 st_q;
        logic [KW-1:0]          k_q;
        logic signed [ACCW-1:0] acc_q;
        logic signed [ACCW-1:0] acc_d;
        logic signed [ACCW-1:0] prod_w;
        logic signed [DW-1:0]   x_q [TAPS];
        logic signed [CW-1:0]   c_w;
        logic                   mode_q;
        logic                   done_w;
        logic                   fin_q;

        // Downstream stages take the upstream result on the very edge it completes.
        if (i == 0) begin : g_head
            assign din_w[i]    = data_in;
            assign accept_w[i] = data_in_read && (st_q == S_IDLE);
        end else begin : g_link
            assign din_w[i]    = res_w[i-1];
            assign accept_w[i] = emit_w[i-1];
        end

        assign c_w       = mode_q ? chi_q[k_q[AW-1:0]] : clo_q[k_q[AW-1:0]];
        assign prod_w    = ACCW'(x_q[k_q[AW-1:0]]) * ACCW'(c_w);
        assign acc_d     = acc_q + prod_w;
        assign done_w    = (st_q == S_MAC) && (k_q == KW'(TAPS));
        assign res_w[i]  = shift_sat(acc_q);
        assign busy_w[i] = (st_q != S_IDLE);

`ifdef XB_DECIM2_EN
        logic phase_q;

        always_ff @(posedge phy_clk_0 or negedge reset) begin
            if (!reset)      phase_q <= 1'b0;
            else if (done_w) phase_q <= ~phase_q;
        end

        assign emit_w[i] = done_w && !phase_q;
`else
        assign emit_w[i] = done_w;
`endif

        always_ff @(posedge phy_clk_0 or negedge reset) begin
            if (!reset) begin
                st_q   <= S_IDLE;
                k_q    <= '0;
                acc_q  <= '0;
                mode_q <= 1'b0;
                fin_q  <= 1'b0;
                for (int j = 0; j < TAPS; j++) x_q[j] <= '0;
            end else begin
                fin_q <= emit_w[i];
                case (st_q)
                    S_IDLE: begin
                        if (accept_w[i]) begin
                            x_q[0] <= din_w[i];
                            for (int j = 1; j < TAPS; j++) x_q[j] <= x_q[j-1];
                            acc_q  <= '0;
                            mode_q <= stage_mode[i];
                            k_q    <= '0;
                            st_q   <= S_MAC;
                        end
                    end
                    S_MAC: begin
                        if (done_w) begin
                            st_q <= S_IDLE;
                        end else begin
                            acc_q <= acc_d;
                            k_q   <= k_q + KW'(1);
                        end
                    end
                    default: st_q <= S_IDLE;
                endcase
            end
        end

        assign finish_stage[i] = fin_q;
    end

    logic signed [DW-1:0] dout_q;
    logic                 dv_q;
    logic                 finish_q;
    logic                 ovr_q;

    always_ff @(posedge phy_clk_0 or negedge reset) begin
        if (!reset) begin
            dout_q   <= '0;
            dv_q     <= 1'b0;
            finish_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            dv_q     <= emit_w[STAGES-1];
            finish_q <= dv_q;
            if (emit_w[STAGES-1]) dout_q <= res_w[STAGES-1];
            // A dropped sample outranks a simultaneous clear.
            if (data_in_read && !in_ready) ovr_q <= 1'b1;
            else if (ovr_clr)              ovr_q <= 1'b0;
        end
    end

    assign in_ready       = ~busy_w[0];
    assign busy           = |busy_w;
    assign data_out       = dout_q;
    assign data_out_valid = dv_q;
    assign finish         = finish_q;
    assign overrun        = ovr_q;

endmodule

// File: tb/tb_xb_cascade_fir.sv
// Randomised self-checking bench for xb_cascade_fir against a sample-level FIR cascade model.
`timescale 1ns/1ps
module tb_xb_cascade_fir;
    localparam int DW = 16, CW = 16, TAPS = 8, STAGES = 3, FRAC = 15;
    localparam int AW  = $clog2(TAPS);
    localparam int LAT = STAGES * (TAPS + 1);

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic signed [DW-1:0]    data_in = '0;
    logic                    data_in_read = 1'b0;
    logic                    in_ready;
    logic [STAGES-1:0]       stage_mode = '0;
    logic                    coef_we = 1'b0;
    logic                    coef_bank = 1'b0;
    logic [AW-1:0]           coef_addr = '0;
    logic signed [CW-1:0]    coef_data = '0;
    logic                    busy;
    logic signed [DW-1:0]    data_out;
    logic                    data_out_valid;
    logic [STAGES-1:0]       finish_stage;
    logic                    finish;
    logic                    overrun;
    logic                    ovr_clr = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int rd = 0;

    xb_cascade_fir #(.DW(DW), .CW(CW), .TAPS(TAPS), .STAGES(STAGES), .FRAC(FRAC)) dut (
        .phy_clk_0(clk), .reset(reset), .data_in(data_in), .data_in_read(data_in_read),
        .in_ready(in_ready), .stage_mode(stage_mode), .coef_we(coef_we), .coef_bank(coef_bank),
        .coef_addr(coef_addr), .coef_data(coef_data), .busy(busy), .data_out(data_out),
        .data_out_valid(data_out_valid), .finish_stage(finish_stage), .finish(finish),
        .overrun(overrun), .ovr_clr(ovr_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation side: record every result, its cycle, and per-stage pulse counts.
    logic signed [DW-1:0] obs_q [$];
    int                   vcyc_q [$];
    int                   fcyc_q [$];
    int                   fs_cnt [STAGES] = '{default: 0};

    always @(negedge clk) begin
        if (data_out_valid) begin
            obs_q.push_back(data_out);
            vcyc_q.push_back(cyc);
        end
        if (finish) fcyc_q.push_back(cyc);
        for (int s = 0; s < STAGES; s++) if (finish_stage[s]) fs_cnt[s]++;
    end

    // Reference: each stage is y = sat(floor(sum(x[j]*c[j]) / 2^FRAC)) over its sample history.
    longint               m_lo [TAPS];
    longint               m_hi [TAPS];
    longint               m_hist [STAGES][TAPS];
    bit                   m_phase [STAGES];
    int                   m_emit [STAGES] = '{default: 0};
    logic signed [DW-1:0] exp_q [$];

    function automatic longint sat(input longint v);
        longint hi = (longint'(1) << (DW - 1)) - 1;
        longint lo = -(longint'(1) << (DW - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic void m_reset();
        for (int j = 0; j < TAPS; j++) begin
            m_lo[j] = 0;
            m_hi[j] = 0;
        end
        for (int s = 0; s < STAGES; s++) begin
            m_phase[s] = 1'b0;
            for (int j = 0; j < TAPS; j++) m_hist[s][j] = 0;
        end
    endfunction

    function automatic void m_push(input longint sample, input logic [STAGES-1:0] mode);
        longint v = sample;
        longint sum;
        for (int s = 0; s < STAGES; s++) begin
            for (int j = TAPS - 1; j > 0; j--) m_hist[s][j] = m_hist[s][j-1];
            m_hist[s][0] = v;
            sum = 0;
            for (int j = 0; j < TAPS; j++) sum += m_hist[s][j] * (mode[s] ? m_hi[j] : m_lo[j]);
            v = sat(sum >>> FRAC);
`ifdef XB_DECIM2_EN
            if (m_phase[s]) begin
                m_phase[s] = 1'b0;
                return;
            end
            m_phase[s] = 1'b1;
`endif
            m_emit[s]++;
        end
        exp_q.push_back(DW'(v));
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        m_reset();
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL ready_timeout in_ready=%0b required 1", in_ready);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL drain_timeout busy=%0b required 0", busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic write_coef(input logic bank, input logic [AW-1:0] addr,
                              input logic signed [CW-1:0] val, input bit taken);
        coef_we = 1'b1; coef_bank = bank; coef_addr = addr; coef_data = val;
        @(negedge clk);
        coef_we = 1'b0;
        if (taken) begin
            if (bank) m_hi[addr] = longint'(val);
            else      m_lo[addr] = longint'(val);
        end
    endtask

    task automatic drive_sample(input logic signed [DW-1:0] d, input logic [STAGES-1:0] mode);
        wait_ready();
        stage_mode = mode; data_in = d; data_in_read = 1'b1;
        @(negedge clk);
        acc_cyc = cyc;
        data_in_read = 1'b0;
        m_push(longint'(d), mode);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++;
        if ({busy, data_out_valid, finish, overrun} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got busy/dv/fin/ovr=%b exp=0000", {busy, data_out_valid, finish, overrun});
        end
        checks++;
        if (finish_stage !== '0) begin errors++; $display("FAIL reset_finish_stage got=%b exp=000", finish_stage); end
        checks++;
        if (data_out !== '0) begin errors++; $display("FAIL reset_data_out got=%h exp=0000", data_out); end
        reset = 1'b1;
        m_reset();
        @(negedge clk);
    endtask

    task automatic test_impulse();
        int nv, nf, a;
        int fs0 [STAGES];
        fs0 = fs_cnt;
        nv = vcyc_q.size();
        nf = fcyc_q.size();
        write_coef(1'b0, 3'd0, 16'sh7FFF, 1'b1);
        drive_sample(16'sh1000, 3'b000);
        a = acc_cyc;
        drain();
        checks++;
        if (obs_q.size() <= nv) begin
            errors++; $display("FAIL impulse_value got=none exp=0ffd");
        end else if (obs_q[nv] !== 16'h0FFD) begin
            errors++; $display("FAIL impulse_value got=%h exp=0ffd", obs_q[nv]);
        end
        checks++;
        if (vcyc_q.size() <= nv || vcyc_q[nv] != a + LAT) begin
            errors++; $display("FAIL impulse_latency got=%0d exp=%0d", (vcyc_q.size() > nv) ? vcyc_q[nv] - a : -1, LAT);
        end
        checks++;
        if (fcyc_q.size() <= nf || fcyc_q[nf] != a + LAT + 1) begin
            errors++; $display("FAIL impulse_finish got=%0d exp=%0d", (fcyc_q.size() > nf) ? fcyc_q[nf] - a : -1, LAT + 1);
        end
        for (int s = 0; s < STAGES; s++) begin
            checks++;
            if (fs_cnt[s] - fs0[s] != 1) begin
                errors++; $display("FAIL impulse_stage%0d_pulses got=%0d exp=1", s, fs_cnt[s] - fs0[s]);
            end
        end
        drive_sample(16'sh0000, 3'b000);
        drive_sample(16'sh0000, 3'b000);
        drain();
        while (rd < exp_q.size()) begin
            checks++;
            if (rd >= obs_q.size()) begin
                errors++; $display("FAIL impulse_out%0d got=none exp=%h", rd, exp_q[rd]);
            end else if (obs_q[rd] !== exp_q[rd]) begin
                errors++; $display("FAIL impulse_out%0d got=%h exp=%h", rd, obs_q[rd], exp_q[rd]);
            end
            rd++;
        end
    endtask

    task automatic test_mode();
        int nv;
        do_reset();
        nv = obs_q.size();
        write_coef(1'b0, 3'd0, 16'sh7FFF, 1'b1);
        write_coef(1'b1, 3'd0, -16'sh4000, 1'b1);
        drive_sample(16'sh2000, 3'b100);
        drain();
        checks++;
        if (obs_q.size() <= nv || obs_q[nv] !== 16'hF001) begin
            errors++; $display("FAIL mode_value got=%h exp=f001", (obs_q.size() > nv) ? obs_q[nv] : 16'hxxxx);
        end
        rd = obs_q.size();
        exp_q.delete();
        rd = 0;
        obs_q.delete();
    endtask

    task automatic test_saturation(input logic signed [DW-1:0] smp);
        logic signed [DW-1:0] last_exp;
        do_reset();
        for (int j = 0; j < TAPS; j++) write_coef(1'b0, AW'(j), 16'sh7FFF, 1'b1);
        for (int n = 0; n < 8; n++) drive_sample(smp, 3'b000);
        drain();
        last_exp = (smp[DW-1]) ? 16'sh8000 : 16'sh7FFF;
`ifndef XB_DECIM2_EN
        checks++;
        if (obs_q.size() == 0 || obs_q[obs_q.size()-1] !== last_exp) begin
            errors++; $display("FAIL sat_last got=%h exp=%h", (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : 16'hxxxx, last_exp);
        end
`endif
        while (rd < exp_q.size()) begin
            checks++;
            if (rd >= obs_q.size()) begin
                errors++; $display("FAIL sat_out%0d got=none exp=%h", rd, exp_q[rd]);
            end else if (obs_q[rd] !== exp_q[rd] || exp_q[rd] === 16'hxxxx) begin
                errors++; $display("FAIL sat_out%0d got=%h exp=%h", rd, obs_q[rd], exp_q[rd]);
            end
            rd++;
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL sat_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_random();
        logic signed [DW-1:0] smp;
        logic signed [CW-1:0] cv;
        logic [STAGES-1:0]    mode;
        int                   ga;
        int fs0 [STAGES];
        int me0 [STAGES];
        for (int j = 0; j < TAPS; j++) begin
            write_coef(1'b0, AW'(j), CW'(int'($urandom_range(0, 16383)) - 8192), 1'b1);
            write_coef(1'b1, AW'(j), CW'(int'($urandom_range(0, 16383)) - 8192), 1'b1);
        end
        mode = STAGES'($urandom) & ~STAGES'(1);
        fs0 = fs_cnt;
        me0 = m_emit;
        for (int n = 0; n < 16; n++) begin
            smp = DW'($urandom);
            drive_sample(smp, mode);
            if (n == 5) begin
                ga = $urandom_range(2, TAPS - 1);
                cv = CW'(m_lo[ga]) ^ CW'(16'h1234);
                write_coef(1'b0, AW'(ga), cv, 1'b0);
            end
        end
        drain();
        while (rd < exp_q.size()) begin
            checks++;
            if (rd >= obs_q.size()) begin
                errors++; $display("FAIL random_out%0d got=none exp=%h", rd, exp_q[rd]);
            end else if (obs_q[rd] !== exp_q[rd]) begin
                errors++; $display("FAIL random_out%0d got=%h exp=%h", rd, obs_q[rd], exp_q[rd]);
            end
            rd++;
        end
        for (int s = 0; s < STAGES; s++) begin
            checks++;
            if (fs_cnt[s] - fs0[s] != m_emit[s] - me0[s]) begin
                errors++; $display("FAIL random_stage%0d_pulses got=%0d exp=%0d", s, fs_cnt[s] - fs0[s], m_emit[s] - me0[s]);
            end
        end
    endtask

    task automatic test_overrun();
        drive_sample(DW'($urandom), 3'b000);
        @(negedge clk);
        data_in = DW'($urandom); data_in_read = 1'b1;
        @(negedge clk);
        data_in_read = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got=%0b exp=1", overrun); end
        data_in_read = 1'b1; ovr_clr = 1'b1;
        @(negedge clk);
        data_in_read = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set_wins got=%0b exp=1", overrun); end
        @(negedge clk);
        ovr_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got=%0b exp=0", overrun); end
        drain();
        while (rd < exp_q.size()) begin
            checks++;
            if (rd >= obs_q.size()) begin
                errors++; $display("FAIL overrun_out%0d got=none exp=%h", rd, exp_q[rd]);
            end else if (obs_q[rd] !== exp_q[rd]) begin
                errors++; $display("FAIL overrun_out%0d got=%h exp=%h", rd, obs_q[rd], exp_q[rd]);
            end
            rd++;
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL overrun_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int nv;
        wait_ready();
        data_in = 16'sh4000; stage_mode = '0; data_in_read = 1'b1;
        @(negedge clk);
        data_in_read = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_idle got ready/busy=%b exp=10", {in_ready, busy});
        end
        checks++;
        if ({data_out, data_out_valid, finish_stage, finish, overrun} !== '0) begin
            errors++; $display("FAIL midreset_outputs got dout=%h dv=%0b fs=%b fin=%0b ovr=%0b exp all 0",
                               data_out, data_out_valid, finish_stage, finish, overrun);
        end
        @(negedge clk);
        reset = 1'b1;
        m_reset();
        nv = obs_q.size();
        repeat (LAT + 10) @(negedge clk);
        checks++;
        if (obs_q.size() != nv) begin
            errors++; $display("FAIL midreset_no_valid got=%0d exp=0", obs_q.size() - nv);
        end
    endtask

    task automatic test_decim();
        int fs0 [STAGES];
        int nv;
        int exp_cnt [STAGES];
        do_reset();
        fs0 = fs_cnt;
        nv = obs_q.size();
`ifdef XB_DECIM2_EN
        exp_cnt = '{4, 2, 1};
`else
        exp_cnt = '{8, 8, 8};
`endif
        write_coef(1'b0, 3'd0, 16'sh4000, 1'b1);
        write_coef(1'b0, 3'd1, 16'sh2000, 1'b1);
        for (int n = 0; n < 8; n++) drive_sample(DW'($urandom), 3'b000);
        drain();
        for (int s = 0; s < STAGES; s++) begin
            checks++;
            if (fs_cnt[s] - fs0[s] != exp_cnt[s]) begin
                errors++; $display("FAIL decim_stage%0d_pulses got=%0d exp=%0d", s, fs_cnt[s] - fs0[s], exp_cnt[s]);
            end
        end
        checks++;
        if (obs_q.size() - nv != exp_cnt[STAGES-1]) begin
            errors++; $display("FAIL decim_valid_pulses got=%0d exp=%0d", obs_q.size() - nv, exp_cnt[STAGES-1]);
        end
        while (rd < exp_q.size()) begin
            checks++;
            if (rd >= obs_q.size()) begin
                errors++; $display("FAIL decim_out%0d got=none exp=%h", rd, exp_q[rd]);
            end else if (obs_q[rd] !== exp_q[rd]) begin
                errors++; $display("FAIL decim_out%0d got=%h exp=%h", rd, obs_q[rd], exp_q[rd]);
            end
            rd++;
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_mode();
        test_saturation(16'sh7FFF);
        test_saturation(-16'sh8000);
        test_random();
        test_overrun();
        test_reset_mid();
        test_decim();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog cycles=%0d limit reached", cyc);
        $fatal(1);
    end

endmodule

// File: doc/xb_cascade_fir.md
# xb_cascade_fir

Parametrised cascaded wavelet filter bank that replaces the fixed three-stage low/low/high filter chain. STAGES serial-MAC FIR stages are chained, each TAPS long. Each stage selects at run time between a shared low-pass and a shared high-pass coefficient bank, both loaded through a write port. It sits between the sample read path (`rd_data`/`data_in_read`) and the downstream consumer, and reports per-stage and final completion strobes.

## Interface
- DW, 16, signed sample width (input, inter-stage and output)
- CW, 16, signed coefficient width
- TAPS, 8, taps per stage (≥2); AW = $clog2(TAPS)
- STAGES, 3, number of cascaded stages (≥1)
- FRAC, 15, arithmetic right shift applied to the accumulator before saturation

- phy_clk_0  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- data_in  in  DW  input sample
- data_in_read  in  1  input sample strobe, one cycle per sample
- in_ready  out  1  stage 0 idle and able to accept
- stage_mode  in  STAGES  bit i: 0 = stage i uses the low bank, 1 = high bank
- coef_we  in  1  coefficient write strobe
- coef_bank  in  1  0 = low bank, 1 = high bank
- coef_addr  in  AW  tap index
- coef_data  in  CW  coefficient value
- busy  out  1  any stage not IDLE
- data_out  out  DW  final-stage result, held until the next result
- data_out_valid  out  1  one-cycle pulse with each new data_out
- finish_stage  out  STAGES  bit i pulses when stage i produces a result
- finish  out  1  data_out_valid delayed by one register
- overrun  out  1  sticky flag: a sample was dropped
- ovr_clr  in  1  clears overrun

## Operation
- Stage FSM has two states: IDLE and MAC.
  - IDLE→MAC on accept. Stage 0 accepts `data_in_read & in_ready`. Stage i>0 accepts `finish_stage[i-1]`.
  - On accept the stage shifts the sample into its TAPS-deep delay line (x[0] = newest), clears the accumulator, latches its stage_mode bit, and sets k=0.
  - In MAC: acc += x[k]*c[k] each cycle, k increments.
  - After k=TAPS-1 is consumed, the next edge loads the output register, pulses finish_stage[i], and returns the stage to IDLE.
- Accumulator width: DW+CW+AW, signed.
- Result = acc >>> FRAC (floor), saturated to [-2^(DW-1), 2^(DW-1)-1].
- Coefficient writes:
  - Accepted only when busy=0; writes while busy are ignored.
  - The bank is selected by coef_bank and the tap by coef_addr. Out-of-range addresses are ignored.
- A stage i>0 is always IDLE when its predecessor completes, because all stages have equal period.
- A stage-0 strobe while in_ready=0 drops the sample and sets overrun. Stage state is unaffected.
- ovr_clr clears overrun. If ovr_clr and an overrun occur in the same cycle, set wins.
- The final stage's result drives data_out/data_out_valid. finish follows data_out_valid one cycle later.

## Timing
- Accept at edge E0. Stage i result is registered at E(TAPS+1).
- Minimum stage-0 sample period: TAPS+2 cycles.
- End-to-end latency: STAGES*(TAPS+1) edges to data_out_valid, +1 edge to finish.
- Reset values:
  - all outputs 0 except in_ready=1
  - delay lines, accumulators, both coefficient banks and stage_mode latches 0
  - all FSMs IDLE
- Reset asserted mid-MAC aborts all stages immediately. No valid pulse is emitted afterwards for the aborted sample.
- An accept coincident with a stage's return to IDLE is not possible (in_ready is low during that edge). The first accept lands on the following edge.

## Configuration
- XB_DECIM2_EN defined:
  - Each stage has a 1-bit phase toggle, reset to 0, flipped on every computed result.
  - finish_stage[i] and the forwarded result are emitted only when the phase was 0, i.e. 1st, 3rd, 5th... result.
  - Each stage therefore downsamples by 2, and the final output rate is input/2^STAGES.
- XB_DECIM2_EN undefined: every computed result is emitted and no phase logic exists.

## Test plan
Defaults throughout (DW=16, CW=16, TAPS=8, STAGES=3, FRAC=15).

- Impulse pass-through:
  - Stimulus: low c[0]=0x7FFF, others 0; stage_mode=3'b000; data_in=0x1000, then zeros.
  - Response: finish_stage values 0x0FFF, 0x0FFE, 0x0FFD; data_out=0x0FFD at edge 27 after accept; finish at edge 28.
- Mode select:
  - Stimulus: additionally high c[0]=0xC000; stage_mode=3'b100; data_in=0x2000.
  - Response: stage outputs 0x1FFF, 0x1FFE, 0xF001.
- Saturation:
  - Stimulus: all low taps 0x7FFF; eight samples of 0x7FFF.
  - Response: 8th stage-0 result is 0x7FFF. Repeating with 0x8000 samples gives 0x8000.
- Overrun:
  - Stimulus: data_in_read pulsed 2 cycles after an accept.
  - Response: overrun=1; first sample's output is unchanged; ovr_clr returns overrun to 0.
- Reset mid-MAC and write guard:
  - Stimulus: assert reset 4 cycles after accept; separately pulse coef_we while busy=1.
  - Response (reset): all outputs 0, in_ready=1, no valid pulse follows.
  - Response (write guard): the coefficient stays unchanged.
- XB_DECIM2_EN:
  - Stimulus: 8 samples spaced 10 cycles apart.
  - Response: 4, 2, 1 pulses on finish_stage[0..2]; exactly 1 data_out_valid. Without the macro: 8 of each.
